// File: rtl/arbitro_paridade_if.sv
// Handshake and result bundle for the shared parity checker.
// The master side offers words from two requesters and the slave side returns parity results.
interface arbitro_paridade_if #(
  parameter int LARGURA = 8
);
  logic               req0_valid;
  logic [LARGURA-1:0] req0_dado;
  logic               req0_pronto;
  logic               req1_valid;
  logic [LARGURA-1:0] req1_dado;
  logic               req1_pronto;
  logic               saida_valida;
  logic               saida_id;
  logic               saida_paridade;
  logic               ocupado;

  modport master (
    output req0_valid, req0_dado, req1_valid, req1_dado,
    input  req0_pronto, req1_pronto, saida_valida, saida_id, saida_paridade, ocupado
  );

  modport slave (
    input  req0_valid, req0_dado, req1_valid, req1_dado,
    output req0_pronto, req1_pronto, saida_valida, saida_id, saida_paridade, ocupado
  );
endinterface

// File: rtl/arbitro_paridade.sv
// Two requesters share a single serial parity accumulator, one bit per cycle.
// Conflicts are resolved round-robin; each result is reported as a one-cycle pulse.
module arbitro_paridade #(
  parameter int LARGURA = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  arbitro_paridade_if.slave    bus
);

  typedef enum logic [1:0] {
    OCIOSO,
    SERIAL,
    RESULTADO
  } estado_t;

  localparam int            CW      = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(LARGURA - 1);

  estado_t            estado_q, estado_d;
  logic               ultimo_q, ultimo_d;
  logic               id_q, id_d;
  logic               acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] shift_q, shift_d;
  logic               saida_valida_q, saida_valida_d;
  logic               saida_id_q, saida_id_d;
  logic               saida_paridade_q, saida_paridade_d;

  logic               grant;
  logic               pronto0;
  logic               pronto1;

  // With both requesters waiting, the one not served last wins.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~ultimo_q;
    end
    pronto0 = (estado_q == OCIOSO) && !reset && bus.req0_valid && !grant;
    pronto1 = (estado_q == OCIOSO) && !reset && bus.req1_valid &&  grant;
  end

  always_comb begin
    estado_d         = estado_q;
    ultimo_d         = ultimo_q;
    id_d             = id_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    shift_d          = shift_q;
    saida_valida_d   = 1'b0;
    saida_id_d       = saida_id_q;
    saida_paridade_d = saida_paridade_q;

    case (estado_q)
      OCIOSO: begin
        if (pronto0 || pronto1) begin
          shift_d  = pronto1 ? bus.req1_dado : bus.req0_dado;
          id_d     = pronto1;
          ultimo_d = pronto1;
          acc_d    = 1'b0;
          cnt_d    = '0;
          estado_d = SERIAL;
        end
      end
      SERIAL: begin
        acc_d   = acc_q ^ shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // The final bit is folded straight into the registered result.
        if (cnt_q == CNT_FIM) begin
          estado_d         = RESULTADO;
          saida_valida_d   = 1'b1;
          saida_paridade_d = acc_q ^ shift_q[0];
          saida_id_d       = id_q;
        end
      end
      RESULTADO: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      ultimo_q         <= 1'b1;
      id_q             <= 1'b0;
      acc_q            <= 1'b0;
      cnt_q            <= '0;
      shift_q          <= '0;
      saida_valida_q   <= 1'b0;
      saida_id_q       <= 1'b0;
      saida_paridade_q <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      ultimo_q         <= ultimo_d;
      id_q             <= id_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      shift_q          <= shift_d;
      saida_valida_q   <= saida_valida_d;
      saida_id_q       <= saida_id_d;
      saida_paridade_q <= saida_paridade_d;
    end
  end

  assign bus.req0_pronto    = pronto0;
  assign bus.req1_pronto    = pronto1;
  assign bus.saida_valida   = saida_valida_q;
  assign bus.saida_id       = saida_id_q;
  assign bus.saida_paridade = saida_paridade_q;
  assign bus.ocupado        = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_paridade.sv
// Directed and randomized checks of the shared parity arbiter with LARGURA = 8.
module tb_arbitro_paridade;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arbitro_paridade_if #(.LARGURA(8)) bus ();

  arbitro_paridade #(.LARGURA(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1);
    bus.req0_valid = v0;
    bus.req0_dado  = d0;
    bus.req1_valid = v1;
    bus.req1_dado  = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One isolated word: handshake, nine busy cycles, result on the ninth, then idle.
  task automatic checkWord(input string tag, input logic id, input logic [7:0] dado,
                           input logic exp_par);
    applyStimulus(!id, dado, id, dado);
    checkOutput({tag, "_pronto"}, id ? bus.req1_pronto : bus.req0_pronto, 1);
    checkOutput({tag, "_pronto_outro"}, id ? bus.req0_pronto : bus.req1_pronto, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 8'h00);
    for (int k = 1; k <= 9; k++) begin
      checkOutput({tag, "_ocupado"}, bus.ocupado, 1);
      checkOutput({tag, "_valida"}, bus.saida_valida, (k == 9));
      if (k < 9) tick();
    end
    checkOutput({tag, "_id"}, bus.saida_id, id);
    checkOutput({tag, "_paridade"}, bus.saida_paridade, exp_par);
    tick();
    checkOutput({tag, "_valida_fim"}, bus.saida_valida, 0);
    checkOutput({tag, "_ocupado_fim"}, bus.ocupado, 0);
    checkOutput({tag, "_paridade_retida"}, bus.saida_paridade, exp_par);
    checkOutput({tag, "_id_retido"}, bus.saida_id, id);
  endtask

  task automatic pulseReset();
    applyStimulus(0, 8'h00, 0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic        m_ult;
  logic        m_id;
  logic [7:0]  m_word;
  logic        rv0, rv1, g, exp_p0, exp_p1;
  logic [7:0]  rd0, rd1;
  logic [7:0]  lixo;
  int          phase;
  int          words;
  int          cyc;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1, 8'hB5, 1, 8'h3C);
    tick();
    tick();
    checkOutput("reset_pronto0", bus.req0_pronto, 0);
    checkOutput("reset_pronto1", bus.req1_pronto, 0);
    checkOutput("reset_ocupado", bus.ocupado, 0);
    checkOutput("reset_valida", bus.saida_valida, 0);
    checkOutput("reset_id", bus.saida_id, 0);
    checkOutput("reset_paridade", bus.saida_paridade, 0);
    applyStimulus(0, 8'h00, 0, 8'h00);
    reset = 1'b0;
    tick();
    checkOutput("idle_ocupado", bus.ocupado, 0);

    checkWord("w0_b5", 1'b0, 8'hB5, 1'b1);
    checkWord("w1_3c", 1'b1, 8'h3C, 1'b0);
    checkWord("w1_00", 1'b1, 8'h00, 1'b0);
    checkWord("w1_ff", 1'b1, 8'hFF, 1'b0);
    checkWord("w1_80", 1'b1, 8'h80, 1'b1);

    // Valid dropped before any edge: nothing consumed.
    applyStimulus(1, 8'h01, 0, 8'h00);
    applyStimulus(0, 8'h01, 0, 8'h00);
    tick();
    checkOutput("drop_ocupado", bus.ocupado, 0);

    pulseReset();
    applyStimulus(1, 8'h01, 1, 8'h03);
    for (int w = 0; w < 4; w++) begin
      checkOutput("rr_pronto0", bus.req0_pronto, (w % 2 == 0));
      checkOutput("rr_pronto1", bus.req1_pronto, (w % 2 == 1));
      tick();
      for (int k = 1; k <= 9; k++) begin
        checkOutput("rr_pronto0_ocup", bus.req0_pronto, 0);
        checkOutput("rr_pronto1_ocup", bus.req1_pronto, 0);
        checkOutput("rr_valida", bus.saida_valida, (k == 9));
        if (k < 9) tick();
      end
      checkOutput("rr_id", bus.saida_id, (w % 2 == 1));
      checkOutput("rr_paridade", bus.saida_paridade, (w % 2 == 0));
      tick();
    end
    applyStimulus(0, 8'h00, 0, 8'h00);
    tick();
    tick();

    applyStimulus(1, 8'hB5, 0, 8'h00);
    checkOutput("ign_pronto0_inicio", bus.req0_pronto, 1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      lixo = 8'(k * 37);
      if (k < 9) applyStimulus(1, lixo, k[0], 8'hFF);
      else       applyStimulus(0, lixo, 0, 8'hFF);
      checkOutput("ign_pronto0", bus.req0_pronto, 0);
      checkOutput("ign_pronto1", bus.req1_pronto, 0);
      checkOutput("ign_valida", bus.saida_valida, (k == 9));
      if (k < 9) tick();
    end
    checkOutput("ign_id", bus.saida_id, 0);
    checkOutput("ign_paridade", bus.saida_paridade, 1);
    tick();

    // Serve req0 so the pointer leaves its reset value, then abort mid-word.
    applyStimulus(1, 8'hFF, 0, 8'h00);
    tick();
    applyStimulus(0, 8'h00, 0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("abort_ocupado_antes", bus.ocupado, 1);
    applyStimulus(1, 8'h01, 1, 8'h01);
    reset = 1'b1;
    #1;
    checkOutput("abort_ocupado", bus.ocupado, 0);
    checkOutput("abort_valida", bus.saida_valida, 0);
    checkOutput("abort_pronto0", bus.req0_pronto, 0);
    checkOutput("abort_pronto1", bus.req1_pronto, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checkOutput("abort_sem_valida", bus.saida_valida, 0);
      tick();
    end
    applyStimulus(1, 8'h80, 1, 8'h00);
    checkOutput("abort_grant0", bus.req0_pronto, 1);
    checkOutput("abort_grant1", bus.req1_pronto, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 8'h00);
    for (int k = 1; k < 9; k++) tick();
    checkOutput("abort_res_valida", bus.saida_valida, 1);
    checkOutput("abort_res_id", bus.saida_id, 0);
    checkOutput("abort_res_paridade", bus.saida_paridade, 1);
    tick();

    pulseReset();
    phase = 0;
    m_ult = 1'b1;
    m_id  = 1'b0;
    m_word = 8'h00;
    words = 0;
    cyc   = 0;
    while (words < 1000 && cyc < 20000) begin
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      applyStimulus(rv0, rd0, rv1, rd1);
      g      = (rv0 && rv1) ? !m_ult : rv1;
      exp_p0 = (phase == 0) && rv0 && !g;
      exp_p1 = (phase == 0) && rv1 && g;
      checkOutput("rnd_pronto0", bus.req0_pronto, exp_p0);
      checkOutput("rnd_pronto1", bus.req1_pronto, exp_p1);
      checkOutput("rnd_ocupado", bus.ocupado, (phase != 0));
      checkOutput("rnd_valida", bus.saida_valida, (phase == 9));
      if (phase == 9) begin
        checkOutput("rnd_id", bus.saida_id, m_id);
        checkOutput("rnd_paridade", bus.saida_paridade, ^m_word);
        words++;
      end
      if (exp_p0 || exp_p1) begin
        m_word = exp_p1 ? rd1 : rd0;
        m_id   = exp_p1;
        m_ult  = exp_p1;
        phase  = 1;
      end else if (phase != 0) begin
        phase = (phase == 9) ? 0 : phase + 1;
      end
      tick();
      cyc++;
    end
    checkOutput("rnd_palavras", words, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
